// File: rtl/adrv9001_rx_pkg.sv
// Shared types and widths for the ADRV9001 RX AXI4-Stream packing path.
package adrv9001_rx_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int FIFO_WORD_W = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // FIFO word layout: {tlast, Q, I}
  function automatic logic [FIFO_WORD_W-1:0] pack_word(
    input logic        tlast,
    input logic [15:0] q,
    input logic [15:0] i
  );
    return {tlast, q, i};
  endfunction

endpackage

// File: rtl/adrv9001_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a word written at edge N becomes
// readable after edge N+1.
module adrv9001_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             pending
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      vis_ptr_r;
  logic [AW:0]      rd_ptr_r;

  // vis_ptr_r trails wr_ptr_r by one cycle, giving the one-cycle fall-through latency
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (vis_ptr_r == rd_ptr_r);
  assign pending = (wr_ptr_r != rd_ptr_r);
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {(AW+1){1'b0}};
      vis_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r  <= {(AW+1){1'b0}};
    end else begin
      vis_ptr_r <= wr_ptr_r;
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/adrv9001_rx_axis_packer.sv
// Packs aligned I/Q samples into 32-bit AXI4-Stream beats with length/last
// framing, packet-aligned start/stop and overflow accounting.
module adrv9001_rx_axis_packer
  import adrv9001_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            i_in,
  input  logic [15:0]            q_in,
  input  logic                   valid_in,
  input  logic                   last_in,
  input  logic [CNT_W-1:0]       pkt_len,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   busy
);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       len_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       drop_cnt_r;
  logic                   overflow_r;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fifo_pend_s;
  logic                   rd_en_s;
  logic                   cap_s;
  logic                   wr_en_s;
  logic                   drop_s;
  logic                   tlast_s;
  logic [FIFO_WORD_W-1:0] wr_word_s;
  logic [FIFO_WORD_W-1:0] rd_word_s;

  // A full FIFO still accepts when a beat leaves in the same cycle
  assign cap_s     = valid_in && (state_r != IDLE);
  assign rd_en_s   = !fifo_empty_s && m_axis_tready;
  assign wr_en_s   = cap_s && (!fifo_full_s || rd_en_s);
  assign drop_s    = cap_s && !wr_en_s;
  assign tlast_s   = ((len_r != {CNT_W{1'b0}}) && (cnt_r == (len_r - CNT_W'(1))))
                     || last_in || (state_r == STOP);
  assign wr_word_s = pack_word(tlast_s, q_in, i_in);

  assign m_axis_tvalid = !fifo_empty_s;
  assign m_axis_tdata  = rd_word_s[AXIS_DATA_W-1:0];
  assign m_axis_tlast  = rd_word_s[FIFO_WORD_W-1];
  assign overflow      = overflow_r;
  assign drop_count    = drop_cnt_r;
  assign busy          = (state_r != IDLE) || fifo_pend_s;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN: begin
        // A packet already closing as enable falls needs no STOP phase
        if (!enable) begin
          if (wr_en_s && tlast_s) state_nxt_s = IDLE;
          else                    state_nxt_s = STOP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOP: begin
        if (wr_en_s) state_nxt_s = IDLE;
        else         state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and packet length latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      len_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && enable) begin
        len_r <= pkt_len;
      end
    end
  end

  // Sample counter and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        cnt_r <= tlast_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  adrv9001_sync_fifo #(
    .WIDTH(FIFO_WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en_s),
    .wr_data(wr_word_s),
    .full   (fifo_full_s),
    .rd_en  (rd_en_s),
    .rd_data(rd_word_s),
    .empty  (fifo_empty_s),
    .pending(fifo_pend_s)
  );

endmodule

// File: tb/tb_adrv9001_rx_axis_packer.sv
// Scoreboard bench for adrv9001_rx_axis_packer: directed stimulus pushes
// expected beats, a negedge monitor pops and compares them.
module tb_adrv9001_rx_axis_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] i_in = 16'd0;
  logic [15:0] q_in = 16'd0;
  logic        valid_in = 1'b0;
  logic        last_in = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        overflow;
  logic [15:0] drop_count;
  logic        busy;

  logic [32:0] exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [32:0] prev_word = 33'd0;

  adrv9001_rx_axis_packer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i_in         (i_in),
    .q_in         (q_in),
    .valid_in     (valid_in),
    .last_in      (last_in),
    .pkt_len      (pkt_len),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pop/compare on each transfer and verify hold-while-stalled
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_stable", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {31'd0, 1'b1, prev_word});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {31'd0, m_axis_tlast, m_axis_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("beat", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one sample for one cycle; push the expected beat if it should emerge
  task automatic put(input logic [15:0] i, input logic [15:0] q, input logic l,
                     input logic acc, input logic exp_last);
    valid_in = 1'b1;
    i_in     = i;
    q_in     = q;
    last_in  = l;
    if (acc) exp_q.push_back({exp_last, q, i});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 200) begin
      idle(1);
      k++;
    end
    check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
    check({name, "_queue_empty"}, exp_q.size(), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_drop", {48'd0, drop_count}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;

    // Length framing, pkt_len=4, closed by a STOP sample
    pkt_len = 16'd4;
    enable  = 1'b1;
    idle(1);
    put(16'd0, 16'h0100, 1'b0, 1'b1, 1'b0);
    check("latency_not_yet", {63'd0, m_axis_tvalid}, 64'd0);
    put(16'd1, 16'h0101, 1'b0, 1'b1, 1'b0);
    check("latency_one_cycle", {63'd0, m_axis_tvalid}, 64'd1);
    for (int n = 2; n < 10; n++)
      put(16'(n), 16'(16'h0100 + n), 1'b0, 1'b1, (n == 3) || (n == 7));
    enable = 1'b0;
    idle(1);
    put(16'd10, 16'h010A, 1'b0, 1'b1, 1'b1);
    wait_drain("len");

    // last_in framing, pkt_len=0
    pkt_len = 16'd0;
    enable  = 1'b1;
    idle(1);
    for (int n = 0; n < 6; n++)
      put(16'(16'h0020 + n), 16'h0200, (n == 2), 1'b1, (n == 2));
    enable = 1'b0;
    idle(1);
    put(16'h002F, 16'h0200, 1'b0, 1'b1, 1'b1);
    wait_drain("last");

    // Back-pressure and overflow
    m_axis_tready = 1'b0;
    enable        = 1'b1;
    idle(1);
    for (int n = 0; n < 20; n++)
      put(16'(n), 16'd0, 1'b0, (n < 16), 1'b0);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_drop_count", {48'd0, drop_count}, 64'd4);
    check("ovf_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    idle(3);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 40 && m_axis_tvalid; k++) idle(1);
    check("ovf_drained", exp_q.size(), 64'd0);
    enable = 1'b0;
    idle(1);
    put(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b1);
    wait_drain("ovf");

    // Packet-aligned stop
    pkt_len = 16'd8;
    enable  = 1'b1;
    idle(1);
    for (int n = 0; n < 3; n++)
      put(16'(16'h0040 + n), 16'h0300, 1'b0, 1'b1, 1'b0);
    enable = 1'b0;
    idle(1);
    put(16'h0043, 16'h0300, 1'b0, 1'b1, 1'b1);
    check("stop_busy_pending", {63'd0, busy}, 64'd1);
    put(16'h0044, 16'h0300, 1'b0, 1'b0, 1'b0);
    put(16'h0045, 16'h0300, 1'b1, 1'b0, 1'b0);
    wait_drain("stop");

    // Full FIFO with simultaneous read and write
    pkt_len       = 16'd0;
    m_axis_tready = 1'b0;
    enable        = 1'b1;
    idle(1);
    for (int n = 0; n < 16; n++)
      put(16'(16'h0060 + n), 16'h0400, 1'b0, 1'b1, 1'b0);
    m_axis_tready = 1'b1;
    put(16'h0070, 16'h0400, 1'b0, 1'b1, 1'b0);
    check("simul_no_drop", {48'd0, drop_count}, 64'd4);
    enable = 1'b0;
    idle(1);
    put(16'h0071, 16'h0400, 1'b0, 1'b1, 1'b1);
    wait_drain("simul");

    // Enable falls on a length-tlast sample: straight to IDLE
    pkt_len = 16'd2;
    enable  = 1'b1;
    idle(1);
    put(16'h0080, 16'h0500, 1'b0, 1'b1, 1'b0);
    enable = 1'b0;
    put(16'h0081, 16'h0500, 1'b0, 1'b1, 1'b1);
    put(16'h0082, 16'h0500, 1'b0, 1'b0, 1'b0);
    wait_drain("lenstop");

    // Reset mid-packet
    pkt_len       = 16'd8;
    m_axis_tready = 1'b0;
    enable        = 1'b1;
    idle(1);
    for (int n = 0; n < 5; n++)
      put(16'(16'h0090 + n), 16'h0600, 1'b0, 1'b0, 1'b0);
    rst    = 1'b1;
    enable = 1'b0;
    idle(1);
    rst = 1'b0;
    check("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("mid_rst_overflow", {63'd0, overflow}, 64'd0);
    check("mid_rst_drop", {48'd0, drop_count}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    idle(1);
    for (int n = 0; n < 8; n++) begin
      if (n == 7) enable = 1'b0;
      put(16'(16'h00A0 + n), 16'h0700, 1'b0, 1'b1, (n == 7));
    end
    wait_drain("restart");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adrv9001_rx_axis_packer.md
Name: adrv9001_rx_axis_packer

Overview:
- Downstream neighbour of the RX serdes aligner. Consumes strobe-aligned 16-bit I/Q samples with valid/last and packs each I/Q pair into one 32-bit AXI4-Stream beat.
- Frames beats into packets by a programmable length or by the upstream last flag.
- Buffers in a small FIFO to absorb DMA back-pressure, and reports dropped samples on overflow.
- Supports packet-aligned start/stop under software enable.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- CNT_W, 16, width of pkt_len, sample counter and drop counter.

Ports:
- clk  in  1  main clock; all logic single-domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable (level).
- i_in  in  16  aligned I sample.
- q_in  in  16  aligned Q sample.
- valid_in  in  1  sample valid (one sample per asserted cycle).
- last_in  in  1  upstream end-of-stream; meaningful only with valid_in.
- pkt_len  in  CNT_W  samples per packet; 0 = no length framing. Sampled only in IDLE.
- m_axis_tdata  out  32  {Q[15:0], I[15:0]}.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  packet end.
- overflow  out  1  sticky; set on any dropped sample, cleared only by rst.
- drop_count  out  CNT_W  dropped-sample count, saturating at all-ones.
- busy  out  1  high when state != IDLE or FIFO not empty.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, FIFO emptied, sample counter=0.
  - All outputs 0: tvalid, tlast, tdata, overflow, drop_count, busy.
  - rst mid-packet discards FIFO contents with no tlast emitted.
- FSM states: IDLE, RUN, STOP.
  - IDLE -> RUN when enable=1. pkt_len is latched into len_r on this transition.
  - Samples arriving in the transition cycle are not captured; the first captured sample is the first valid_in seen in RUN.
  - RUN -> STOP when enable=0.
  - STOP: the next accepted sample is written with tlast=1, then -> IDLE.
  - If a sample in RUN already carries a length or last_in tlast in the same cycle enable falls, go straight to IDLE.
  - If the FIFO is full in STOP, remain in STOP; dropped samples do not close the packet.
  - valid_in and last_in are ignored in IDLE.
- Accept rule: sample written iff valid_in=1, state is RUN or STOP, and the FIFO is not full. Write and read in the same cycle are both legal when full.
- Drop rule:
  - valid_in=1 in RUN/STOP with FIFO full (and no simultaneous read) -> sample dropped.
  - On a drop: overflow<=1, drop_count+1 (saturating).
  - Dropped samples do not advance the sample counter.
- FIFO word: 33 bits = {tlast, Q, I}.
- Framing tlast=1 on a written sample when any of these holds:
  - len_r != 0 and counter == len_r-1;
  - last_in=1;
  - state is STOP.
- Counter: +1 on each written sample; wraps to 0 on any written tlast sample.
- Output:
  - First-word-fall-through FIFO.
  - A sample written at edge N appears on m_axis_* after edge N+1 when the FIFO was empty (1-cycle latency).
  - Beat transfers when tvalid & tready.
  - tdata and tlast must be held stable while tvalid=1 and tready=0.
- Full throughput: one sample per clock sustained while tready=1.
- busy: combinational OR of (state != IDLE) and FIFO-not-empty.
- Pointer arithmetic: log2(FIFO_DEPTH)+1 bit pointers; the MSB distinguishes full from empty; wrap is natural binary.

Decomposition:
- Package adrv9001_rx_pkg holds:
  - state enum (IDLE, RUN, STOP);
  - AXIS_DATA_W=32;
  - FIFO_WORD_W=33.
- Sub-module adrv9001_sync_fifo:
  - parameterised width/depth, FWFT, single clock;
  - ports: wr_en, wr_data, full, rd_en, rd_data, empty.
- The packer holds the FSM, counter, framing and drop logic.

Test Plan:
- Length framing: pkt_len=4, enable=1, 10 back-to-back samples (I=n, Q=0x100+n), tready=1 -> tdata 0x0100_0000..0x0109_0009; tlast on beats 3 and 7; first beat one cycle after first write.
- last_in framing: pkt_len=0, 6 samples with last_in on the 3rd -> tlast only on beat 2; counter restarts and no further tlast.
- Back-pressure/overflow: FIFO_DEPTH=16, tready=0, 20 samples -> 16 stored; overflow=1; drop_count=4. Release tready -> exactly 16 beats, data 0..15 in order, tdata stable while stalled.
- Packet-aligned stop: pkt_len=8, drop enable after 3 samples -> 4th accepted sample carries tlast; further valid_in ignored; busy falls after the last beat drains.
- Simultaneous: FIFO full with tready=1 and valid_in=1 in the same cycle -> sample accepted, no drop; enable falls on a length-tlast sample -> direct to IDLE, single tlast.
- Reset mid-packet: rst after 5 of 8 samples -> next cycle tvalid=0, overflow=0, drop_count=0. Restart -> first beat is the new sample 0 with a fresh count.
